// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner codes
// and the read value returned when the watchdog abandons an access.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_D = 2'd1;
  localparam logic [1:0] ST_BUSY_I = 2'd2;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_DM   = 2'd1,
    OWNER_IF   = 2'd2
  } owner_e;

  // An aborted access reports an all-zero read word, built by replicating this bit.
  localparam logic ABORT_RDATA_BIT = 1'b0;

  // Which requester owns the memory port in a given FSM state.
  function automatic owner_e state_owner(input logic [1:0] st);
    owner_e owner;
    case (st)
      ST_BUSY_D: owner = OWNER_DM;
      ST_BUSY_I: owner = OWNER_IF;
      default:   owner = OWNER_NONE;
    endcase
    return owner;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Watchdog counter for the memory port arbiter. It counts cycles spent
// waiting on the memory and flags expiry on the TIMEOUT-th waiting cycle,
// so the arbiter can abandon the access on that same clock edge.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == CW'(TIMEOUT - 1));

  // Count waiting cycles; restart whenever the port is not busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-port memory between instruction
// fetch and the data stage. One transaction runs at a time. Data accesses
// win over fetches. Results are held in done flags and read registers until
// the pipeline advances. stall_o freezes the pipeline while any request is
// still outstanding.
// Optional feature: define MEM_ARB_TIMEOUT_EN to build the watchdog. The
// watchdog abandons accesses the memory never acknowledges and raises a
// sticky err_o. Without it, err_o is tied low.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_port_arbiter: TIMEOUT must lie in 2..255");
  end

  logic [1:0]        state;
  logic              if_done;
  logic              dm_done;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  owner_e            owner;
  logic              busy;
  logic              start_dm;
  logic              start_if;
  logic              abort;
  logic              finish;
  logic [DATA_W-1:0] capture;

  assign owner    = state_owner(state);
  assign busy     = (owner != OWNER_NONE);
  assign stall_o  = (if_req_i & ~if_done) | (dm_req_i & ~dm_done);
  assign start_dm = (state == ST_IDLE) && dm_req_i && !dm_done;
  assign start_if = (state == ST_IDLE) && !start_dm && if_req_i && !if_done;
  assign finish   = busy && (mem_ack_i || abort);

  // Writes and aborted accesses both hand back a zero read word.
  assign capture = (mem_ack_i && !mem_we_o) ? mem_rdata_i : {DATA_W{ABORT_RDATA_BIT}};

  assign if_ack_o   = if_done;
  assign dm_ack_o   = dm_done;
  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
  logic expire;
  logic err_q;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .clear  (!busy),
    .enable (busy),
    .expire (expire)
  );

  // A real acknowledge on the expiry cycle still counts as success.
  assign abort = expire && !mem_ack_i;
  assign err_o = err_q;

  // Sticky error: once an access has been abandoned it stays set until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  // Transaction sequencer: pick a requester in IDLE, hold the memory outputs while busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_dm) begin
            state       <= ST_BUSY_D;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
          end else if (start_if) begin
            state       <= ST_BUSY_I;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
          end
        end
        ST_BUSY_D, ST_BUSY_I: begin
          if (finish) begin
            state     <= ST_IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Done flags and read registers. A completing access sets its flag even if
  // the pipeline advances on the same edge; any stall-free edge clears the flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (!stall_o) begin
        if_done <= 1'b0;
        dm_done <= 1'b0;
      end
      if (finish && owner == OWNER_DM) begin
        dm_done    <= 1'b1;
        dm_rdata_q <= capture;
      end
      if (finish && owner == OWNER_IF) begin
        if_done    <= 1'b1;
        if_rdata_q <= capture;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A table of request patterns
// is run against a bench-side memory responder. Hand-written sequences
// cover reset during a busy access, a request dropped mid-access, and a
// stray acknowledge. With MEM_ARB_TIMEOUT_EN defined, the watchdog abort
// is also exercised.
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rst_n_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          ack_delay;
    int          exp_stall;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  vec_t vecs[6];
  txn_t txn_q[$];

  int checks = 0;
  int errors = 0;
  int mem_delay = 0;
  logic mem_enable = 1'b1;
  logic spurious_ack = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0040) return 32'h8C22_0004;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Memory responder: acknowledges mem_delay cycles after mem_req_o first appears.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (spurious_ack) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
      end else if (mem_req_o && mem_enable) begin
        if (wait_cnt >= mem_delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: every new memory transaction must match the next expected one.
  initial begin
    logic prev_req;
    txn_t exp;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o && !prev_req) begin
        if (txn_q.size() == 0) begin
          check_output("sb_unexpected_txn", mem_addr_o, 32'hFFFF_FFFF);
        end else begin
          exp = txn_q.pop_front();
          check_output("sb_mem_addr", mem_addr_o, exp.addr);
          check_output("sb_mem_we", 32'(mem_we_o), 32'(exp.we));
          if (exp.we) check_output("sb_mem_wdata", mem_wdata_o, exp.wdata);
        end
      end
      prev_req = mem_req_o;
    end
  end

  task automatic wait_mem_req(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_i);
      seen = mem_req_o;
    end
    check_output(name, 32'(seen), 32'd1);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int  stall_cycles;
    bit  released;
    txn_t t;
    @(posedge clk_i);
    #1;
    mem_delay = v.ack_delay;
    if (v.dm_req) begin
      t.addr = v.dm_addr; t.we = v.dm_we; t.wdata = v.dm_wdata;
      txn_q.push_back(t);
    end
    if (v.if_req) begin
      t.addr = v.if_addr; t.we = 1'b0; t.wdata = '0;
      txn_q.push_back(t);
    end
    if_req_i   = v.if_req;
    if_addr_i  = v.if_addr;
    dm_req_i   = v.dm_req;
    dm_we_i    = v.dm_we;
    dm_addr_i  = v.dm_addr;
    dm_wdata_i = v.dm_wdata;
    stall_cycles = 0;
    released = 1'b0;
    for (int c = 0; c < 100 && !released; c++) begin
      @(negedge clk_i);
      if (stall_o) stall_cycles++;
      else released = 1'b1;
    end
    check_output($sformatf("v%0d_released", idx), 32'(released), 32'd1);
    check_output($sformatf("v%0d_stall_cycles", idx), 32'(stall_cycles), 32'(v.exp_stall));
    check_output($sformatf("v%0d_if_ack", idx), 32'(if_ack_o), 32'(v.if_req));
    check_output($sformatf("v%0d_dm_ack", idx), 32'(dm_ack_o), 32'(v.dm_req));
    if (v.if_req) check_output($sformatf("v%0d_if_rdata", idx), if_rdata_o, v.exp_if_rdata);
    if (v.dm_req) check_output($sformatf("v%0d_dm_rdata", idx), dm_rdata_o, v.exp_dm_rdata);
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    @(negedge clk_i);
    check_output($sformatf("v%0d_if_ack_cleared", idx), 32'(if_ack_o), 32'd0);
    check_output($sformatf("v%0d_dm_ack_cleared", idx), 32'(dm_ack_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    check_output({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    check_output({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    check_output({tag, "_if_ack"}, 32'(if_ack_o), 32'd0);
    check_output({tag, "_dm_ack"}, 32'(dm_ack_o), 32'd0);
    check_output({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    check_output({tag, "_dm_rdata"}, dm_rdata_o, 32'd0);
    check_output({tag, "_stall"}, 32'(stall_o), 32'd0);
    check_output({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    txn_t t;
    int   busy_cycles;
    bit   acked;

    vecs[0] = '{1'b1, 32'h40,   1'b0, 1'b0, 32'h0,   32'h0,         2, 4, 32'h8C22_0004, 32'h0};
    vecs[1] = '{1'b1, 32'h40,   1'b1, 1'b0, 32'h10,  32'h0,         1, 6, 32'h8C22_0004, 32'h0010_FFEF};
    vecs[2] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20,  32'h1234_5678, 0, 2, 32'h0,         32'h0};
    vecs[3] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h100, 32'h0,         3, 5, 32'h0,         32'h0100_FEFF};
    vecs[4] = '{1'b1, 32'h44,   1'b1, 1'b1, 32'h80,  32'hCAFE_F00D, 0, 4, 32'h0044_FFBB, 32'h0};
    vecs[5] = '{1'b1, 32'h1234, 1'b0, 1'b0, 32'h0,   32'h0,         0, 2, 32'h1234_EDCB, 32'h0};

    rst_n_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    #3;
    check_all_zero("por");
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

    // Reset while the data access is waiting on memory.
    $display("[TB] reset during busy data access");
    @(posedge clk_i);
    #1;
    mem_enable = 1'b0;
    t.addr = 32'h300; t.we = 1'b0; t.wdata = '0;
    txn_q.push_back(t);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
    wait_mem_req("rst_busy_req_seen");
    #2;
    rst_n_i = 1'b0;
    dm_req_i = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    mem_enable = 1'b1;
    @(negedge clk_i);
    check_output("rst_release_stall", 32'(stall_o), 32'd0);
    check_output("rst_release_mem_req", 32'(mem_req_o), 32'd0);
    apply_stimulus(vecs[0], 10);

    // Fetch request withdrawn while its access is still in flight.
    $display("[TB] fetch dropped mid-access");
    @(posedge clk_i);
    #1;
    mem_delay = 3;
    t.addr = 32'h50; t.we = 1'b0; t.wdata = '0;
    txn_q.push_back(t);
    if_req_i = 1'b1; if_addr_i = 32'h50;
    wait_mem_req("drop_req_seen");
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0;
    @(negedge clk_i);
    check_output("drop_stall_low", 32'(stall_o), 32'd0);
    acked = 1'b0;
    for (int c = 0; c < 20 && !acked; c++) begin
      if (c != 0) @(negedge clk_i);
      acked = if_ack_o;
    end
    check_output("drop_if_ack_seen", 32'(acked), 32'd1);
    check_output("drop_if_rdata", if_rdata_o, 32'h0050_FFAF);
    @(negedge clk_i);
    check_output("drop_if_ack_cleared", 32'(if_ack_o), 32'd0);
    check_output("drop_mem_req_idle", 32'(mem_req_o), 32'd0);

    // A stray acknowledge while idle must change nothing.
    $display("[TB] stray ack in idle");
    @(negedge clk_i);
    spurious_ack = 1'b1;
    @(posedge clk_i);
    #2;
    spurious_ack = 1'b0;
    @(negedge clk_i);
    check_output("stray_mem_ack_driven", 32'(mem_ack_i), 32'd1);
    @(negedge clk_i);
    check_output("stray_dm_ack", 32'(dm_ack_o), 32'd0);
    check_output("stray_if_ack", 32'(if_ack_o), 32'd0);
    check_output("stray_mem_req", 32'(mem_req_o), 32'd0);
    check_output("stray_stall", 32'(stall_o), 32'd0);

    apply_stimulus(vecs[3], 11);

`ifdef MEM_ARB_TIMEOUT_EN
    $display("[TB] watchdog abort");
    @(posedge clk_i);
    #1;
    mem_enable = 1'b0;
    t.addr = 32'h600; t.we = 1'b0; t.wdata = '0;
    txn_q.push_back(t);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h600;
    busy_cycles = 0;
    acked = 1'b0;
    for (int c = 0; c < 50 && !acked; c++) begin
      @(negedge clk_i);
      if (mem_req_o) busy_cycles++;
      acked = dm_ack_o;
    end
    check_output("to_ack_seen", 32'(acked), 32'd1);
    check_output("to_busy_cycles", 32'(busy_cycles), 32'd8);
    check_output("to_dm_rdata", dm_rdata_o, 32'd0);
    check_output("to_err", 32'(err_o), 32'd1);
    check_output("to_stall_released", 32'(stall_o), 32'd0);
    @(posedge clk_i);
    #1;
    dm_req_i = 1'b0;
    mem_enable = 1'b1;
    apply_stimulus(vecs[5], 12);
    check_output("to_err_sticky", 32'(err_o), 32'd1);
`else
    busy_cycles = 0;
    acked = 1'b0;
    check_output("err_tied_low", 32'(err_o), 32'd0);
`endif

    repeat (3) @(negedge clk_i);
    check_output("sb_queue_empty", 32'(txn_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
